topo_order_scheduler: RTL and testbench

Kahn's-algorithm sequencer for the path-counting DAG.
- Sits directly downstream of the per-node indegree store and drives its node-select/decrement update interface.
- Seeds a ready queue with all zero-indegree nodes, pops them in order and walks each node's successor list from the adjacency store, decrementing successor indegrees.
- Emits the resulting topological order to the path-accumulation stage and flags cycles.

---
 rtl/topo_order_scheduler_if.sv | 38 +++
 rtl/topo_order_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_topo_order_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/topo_order_scheduler_if.sv
// Scheduler-facing bundle: run control, indegree-store update port, adjacency
// request/response stream and topological-order output.
interface topo_order_scheduler_if #(
    parameter int unsigned MAX_NODES  = 1024,
    parameter int unsigned NODE_WIDTH = $clog2(MAX_NODES)
);
    logic                  start;
    logic [NODE_WIDTH:0]   node_count;
    logic [NODE_WIDTH-1:0] node_sel;
    logic                  decrement_degree;
    logic [NODE_WIDTH-1:0] node_degree;
    logic                  adj_req;
    logic [NODE_WIDTH-1:0] adj_req_node;
    logic                  adj_rsp_valid;
    logic                  adj_rsp_ready;
    logic [NODE_WIDTH-1:0] adj_rsp_node;
    logic                  adj_rsp_last;
    logic                  adj_rsp_none;
    logic                  order_valid;
    logic [NODE_WIDTH-1:0] order_node;
    logic                  busy;
    logic                  done;
    logic                  cycle_detected;

    modport master (
        input  start, node_count, node_degree,
               adj_rsp_valid, adj_rsp_node, adj_rsp_last, adj_rsp_none,
        output node_sel, decrement_degree, adj_req, adj_req_node, adj_rsp_ready,
               order_valid, order_node, busy, done, cycle_detected
    );

    modport slave (
        output start, node_count, node_degree,
               adj_rsp_valid, adj_rsp_node, adj_rsp_last, adj_rsp_none,
        input  node_sel, decrement_degree, adj_req, adj_req_node, adj_rsp_ready,
               order_valid, order_node, busy, done, cycle_detected
    );
endinterface

// File: rtl/topo_order_scheduler.sv
// Kahn's-algorithm sequencer: seeds a ready FIFO with zero-indegree nodes, emits nodes
// in topological order while decrementing successor indegrees, and flags cycles.
module topo_order_scheduler #(
    parameter int unsigned MAX_NODES  = 1024,
    parameter int unsigned NODE_WIDTH = $clog2(MAX_NODES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    topo_order_scheduler_if.master sched_if
);
    localparam int unsigned CNT_W = NODE_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_POP, S_ADJ, S_DECR, S_DECR_CHK, S_FINISH
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, idx_q, idx_d, emit_q, emit_d;
    logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  last_q, last_d;
    logic [NODE_WIDTH-1:0] node_sel_q, node_sel_d;
    logic [NODE_WIDTH-1:0] adj_req_node_q, adj_req_node_d;
    logic [NODE_WIDTH-1:0] order_node_q, order_node_d;
    logic                  dec_q, dec_d, adj_req_q, adj_req_d, ready_q, ready_d;
    logic                  order_valid_q, order_valid_d;
    logic                  busy_q, busy_d, done_q, done_d, cyc_q, cyc_d;
    logic                  push_c;
    logic [NODE_WIDTH-1:0] push_node_c;

    // Ready FIFO; pointers restart every run, so a run never wraps them
    logic [NODE_WIDTH-1:0] fifo_mem [MAX_NODES];

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        emit_d         = emit_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        last_d         = last_q;
        node_sel_d     = node_sel_q;
        adj_req_node_d = adj_req_node_q;
        order_node_d   = order_node_q;
        ready_d        = ready_q;
        busy_d         = busy_q;
        cyc_d          = cyc_q;
        dec_d          = 1'b0;
        adj_req_d      = 1'b0;
        order_valid_d  = 1'b0;
        done_d         = 1'b0;
        push_c         = 1'b0;
        push_node_c    = node_sel_q;

        unique case (state_q)
            S_IDLE: begin
                if (sched_if.start) begin
                    cnt_d      = sched_if.node_count;
                    emit_d     = '0;
                    idx_d      = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    node_sel_d = '0;
                    cyc_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                // node_degree answers for the index presented one cycle earlier
                if (idx_q != '0 && sched_if.node_degree == '0) begin
                    push_c      = 1'b1;
                    push_node_c = NODE_WIDTH'(idx_q - CNT_W'(1));
                end
                if (idx_q == cnt_q) begin
                    state_d = S_POP;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                    if (idx_d < cnt_q) node_sel_d = NODE_WIDTH'(idx_d);
                end
            end
            S_POP: begin
                if (rd_ptr_q == wr_ptr_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cyc_d   = (emit_q != cnt_q);
                    state_d = S_FINISH;
                end else begin
                    order_valid_d  = 1'b1;
                    order_node_d   = fifo_mem[rd_ptr_q[NODE_WIDTH-1:0]];
                    adj_req_d      = 1'b1;
                    adj_req_node_d = fifo_mem[rd_ptr_q[NODE_WIDTH-1:0]];
                    emit_d         = emit_q + CNT_W'(1);
                    rd_ptr_d       = rd_ptr_q + CNT_W'(1);
                    ready_d        = 1'b1;
                    state_d        = S_ADJ;
                end
            end
            S_ADJ: begin
                if (sched_if.adj_rsp_valid && ready_q) begin
                    ready_d = 1'b0;
                    if (sched_if.adj_rsp_none) begin
                        state_d = S_POP;
                    end else begin
                        node_sel_d = sched_if.adj_rsp_node;
                        dec_d      = 1'b1;
                        last_d     = sched_if.adj_rsp_last;
                        state_d    = S_DECR;
                    end
                end
            end
            S_DECR: begin
                state_d = S_DECR_CHK;
            end
            S_DECR_CHK: begin
                // Post-decrement indegree of the successor still on node_sel
                if (sched_if.node_degree == '0) push_c = 1'b1;
                if (last_q) begin
                    state_d = S_POP;
                end else begin
                    ready_d = 1'b1;
                    state_d = S_ADJ;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (push_c) wr_ptr_d = wr_ptr_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            emit_q         <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            last_q         <= 1'b0;
            node_sel_q     <= '0;
            adj_req_node_q <= '0;
            order_node_q   <= '0;
            dec_q          <= 1'b0;
            adj_req_q      <= 1'b0;
            ready_q        <= 1'b0;
            order_valid_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cyc_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            emit_q         <= emit_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            last_q         <= last_d;
            node_sel_q     <= node_sel_d;
            adj_req_node_q <= adj_req_node_d;
            order_node_q   <= order_node_d;
            dec_q          <= dec_d;
            adj_req_q      <= adj_req_d;
            ready_q        <= ready_d;
            order_valid_q  <= order_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            cyc_q          <= cyc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) fifo_mem[wr_ptr_q[NODE_WIDTH-1:0]] <= push_node_c;
    end

    assign sched_if.node_sel         = node_sel_q;
    assign sched_if.decrement_degree = dec_q;
    assign sched_if.adj_req          = adj_req_q;
    assign sched_if.adj_req_node     = adj_req_node_q;
    assign sched_if.adj_rsp_ready    = ready_q;
    assign sched_if.order_valid      = order_valid_q;
    assign sched_if.order_node       = order_node_q;
    assign sched_if.busy             = busy_q;
    assign sched_if.done             = done_q;
    assign sched_if.cycle_detected   = cyc_q;
endmodule

// File: tb/tb_topo_order_scheduler.sv
// Randomized bench for topo_order_scheduler: indegree-store and adjacency-store models
// plus a Kahn reference model whose expected order is checked every cycle.
module tb_topo_order_scheduler;
    localparam int unsigned MAXN = 16;
    localparam int unsigned NW   = 4;
    localparam int unsigned CW   = NW + 1;

    typedef struct {
        int node;
        bit last;
        bit none;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    topo_order_scheduler_if #(.MAX_NODES(MAXN), .NODE_WIDTH(NW)) ifc ();

    topo_order_scheduler #(.MAX_NODES(MAXN), .NODE_WIDTH(NW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sched_if (ifc)
    );

    int    n_err = 0;
    int    n_checks = 0;
    int    n_g;
    int    adj_n [MAXN];
    int    adj_v [MAXN][32];
    int    deg_init [MAXN];
    int    deg [MAXN];
    int    exp_q [$];
    logic  exp_cycle = 1'b0;
    logic  prev_cycle = 1'b0;
    logic  load_deg;
    int    done_cnt = 0;
    int    cyc_n = 0;
    int    last_dec = -10;
    word_t rsp_q [$];
    logic  hs_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, 32'({ifc.node_sel, ifc.decrement_degree, ifc.adj_req, ifc.adj_req_node,
                       ifc.adj_rsp_ready, ifc.order_valid, ifc.order_node, ifc.busy,
                       ifc.done, ifc.cycle_detected}), 32'h0);
    endtask

    // Indegree store: registered read, read-modify-write on decrement
    always @(posedge clk) begin
        if (load_deg) begin
            for (int i = 0; i < MAXN; i++) deg[i] <= deg_init[i];
        end else if (ifc.decrement_degree) begin
            deg[ifc.node_sel] <= deg[ifc.node_sel] - 1;
        end
        ifc.node_degree <= ifc.decrement_degree ? NW'(deg[ifc.node_sel] - 1) : NW'(deg[ifc.node_sel]);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hs_q <= 1'b0;
        else        hs_q <= ifc.adj_rsp_valid && ifc.adj_rsp_ready;
    end

    // Adjacency store: streams the successor list with random gaps
    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_q.delete();
            ifc.adj_rsp_valid = 1'b0;
        end else begin
            if (hs_q) begin
                void'(rsp_q.pop_front());
                ifc.adj_rsp_valid = 1'b0;
            end
            if (ifc.adj_req) begin
                int u;
                u = int'(ifc.adj_req_node);
                if (adj_n[u] == 0) rsp_q.push_back('{node: 0, last: 1'b1, none: 1'b1});
                for (int k = 0; k < adj_n[u]; k++)
                    rsp_q.push_back('{node: adj_v[u][k], last: (k == adj_n[u] - 1), none: 1'b0});
            end
            if (!ifc.adj_rsp_valid && rsp_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                ifc.adj_rsp_valid = 1'b1;
                ifc.adj_rsp_node  = rsp_q[0].none ? NW'($urandom) : NW'(rsp_q[0].node);
                ifc.adj_rsp_last  = rsp_q[0].last;
                ifc.adj_rsp_none  = rsp_q[0].none;
            end
        end
    end

    // Compare process: order stream, decrement legality, completion flags
    always @(negedge clk) begin
        cyc_n++;
        if (!rst_n) begin
            last_dec = -10;
        end else begin
            if (ifc.order_valid) begin
                chk("order_extra", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    int e;
                    e = exp_q.pop_front();
                    chk("order_node", 32'(ifc.order_node), 32'(e));
                    chk("adj_req_with_order", 32'(ifc.adj_req), 32'd1);
                    chk("adj_req_node", 32'(ifc.adj_req_node), 32'(e));
                end
            end else if (ifc.adj_req) begin
                chk("adj_req_stray", 32'(ifc.order_valid), 32'd1);
            end
            if (ifc.decrement_degree) begin
                chk("dec_underflow", 32'(deg[ifc.node_sel] != 0), 32'd1);
                chk("dec_spacing", 32'(cyc_n - last_dec >= 2), 32'd1);
                last_dec = cyc_n;
            end
            if (ifc.done) begin
                chk("missing_nodes", 32'(exp_q.size()), 32'd0);
                chk("cycle_detected", 32'(ifc.cycle_detected), 32'(exp_cycle));
                chk("busy_at_done", 32'(ifc.busy), 32'd0);
                last_dec = -10;
                done_cnt++;
            end
        end
    end

    task automatic clear_graph(input int n);
        n_g = n;
        for (int i = 0; i < MAXN; i++) adj_n[i] = 0;
    endtask

    task automatic add_edge(input int u, input int v);
        adj_v[u][adj_n[u]] = v;
        adj_n[u]++;
    endtask

    // Reference: plain Kahn's algorithm with a FIFO seeded in ascending index order
    task automatic build_model();
        int d [MAXN];
        int q [$];
        int u, v;
        for (int i = 0; i < MAXN; i++) d[i] = 0;
        for (int a = 0; a < n_g; a++)
            for (int k = 0; k < adj_n[a]; k++) d[adj_v[a][k]]++;
        for (int i = 0; i < MAXN; i++) deg_init[i] = d[i];
        exp_q.delete();
        for (int i = 0; i < n_g; i++) if (d[i] == 0) q.push_back(i);
        while (q.size() > 0) begin
            u = q.pop_front();
            exp_q.push_back(u);
            for (int k = 0; k < adj_n[u]; k++) begin
                v = adj_v[u][k];
                d[v]--;
                if (d[v] == 0) q.push_back(v);
            end
        end
        exp_cycle = (exp_q.size() != n_g);
    endtask

    function automatic logic [31:0] pack_exp();
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < exp_q.size() && i < 8; i++) p = p | (32'(exp_q[i]) << (4 * i));
        return p;
    endfunction

    task automatic launch();
        chk("cycle_held", 32'(ifc.cycle_detected), 32'(prev_cycle));
        load_deg = 1'b1;
        @(negedge clk);
        load_deg       = 1'b0;
        ifc.start      = 1'b1;
        ifc.node_count = CW'(n_g);
        @(negedge clk);
        ifc.start = 1'b0;
        chk("busy_after_start", 32'(ifc.busy), 32'd1);
    endtask

    task automatic wait_done();
        int base, t;
        base = done_cnt;
        t = 0;
        while (done_cnt == base && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", 32'(done_cnt != base), 32'd1);
        prev_cycle = exp_cycle;
        @(negedge clk);
    endtask

    task automatic gen_random();
        int n, j, tmp, a, b;
        int perm [MAXN];
        int indeg_c [MAXN];
        n = ($urandom_range(0, 3) == 0) ? MAXN : $urandom_range(1, MAXN);
        for (int i = 0; i < MAXN; i++) begin
            perm[i] = i;
            indeg_c[i] = 0;
        end
        for (int i = n - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        clear_graph(n);
        for (int u = 0; u < n - 1; u++) begin
            for (int e = 0; e < $urandom_range(0, 3); e++) begin
                b = $urandom_range(u + 1, n - 1);
                if (indeg_c[perm[b]] < 14 && adj_n[perm[u]] < 31) begin
                    add_edge(perm[u], perm[b]);
                    indeg_c[perm[b]]++;
                end
            end
        end
        if (n >= 2 && $urandom_range(0, 3) == 0) begin
            a = $urandom_range(0, n - 2);
            b = $urandom_range(a + 1, n - 1);
            if (indeg_c[perm[a]] < 14 && adj_n[perm[b]] < 31) add_edge(perm[b], perm[a]);
        end
    endtask

    initial begin
        int t;
        rst_n              = 1'b0;
        load_deg           = 1'b0;
        ifc.start          = 1'b0;
        ifc.node_count     = '0;
        ifc.adj_rsp_valid  = 1'b0;
        ifc.adj_rsp_node   = '0;
        ifc.adj_rsp_last   = 1'b0;
        ifc.adj_rsp_none   = 1'b0;
        clear_graph(1);
        for (int i = 0; i < MAXN; i++) begin
            deg_init[i] = 0;
            deg[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle_after_reset");

        clear_graph(3); add_edge(0, 1); add_edge(1, 2);
        build_model();
        chk("pin_chain", pack_exp(), 32'h210);
        chk("pin_chain_len", 32'(exp_q.size()), 32'd3);
        launch(); wait_done();

        clear_graph(4); add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3);
        build_model();
        chk("pin_diamond", pack_exp(), 32'h3210);
        launch(); wait_done();

        clear_graph(2); add_edge(0, 1); add_edge(0, 1);
        build_model();
        chk("pin_dup", pack_exp(), 32'h10);
        chk("pin_dup_len", 32'(exp_q.size()), 32'd2);
        launch(); wait_done();

        clear_graph(3); add_edge(0, 1); add_edge(1, 2); add_edge(2, 1);
        build_model();
        chk("pin_cycle_len", 32'(exp_q.size()), 32'd1);
        chk("pin_cycle_flag", 32'(exp_cycle), 32'd1);
        launch();
        @(negedge clk);
        ifc.start      = 1'b1;
        ifc.node_count = CW'(2);
        @(negedge clk);
        ifc.start = 1'b0;
        chk("start_ignored_busy", 32'(ifc.busy), 32'd1);
        wait_done();
        chk("cycle_flag_after", 32'(ifc.cycle_detected), 32'd1);

        clear_graph(4);
        build_model();
        chk("pin_isolated", pack_exp(), 32'h3210);
        launch(); wait_done();

        clear_graph(MAXN);
        for (int i = 0; i < MAXN - 1; i++) add_edge(i, i + 1);
        build_model();
        chk("pin_full_chain_len", 32'(exp_q.size()), 32'(MAXN));
        launch(); wait_done();

        // Reset while waiting on a successor word, then rerun the same graph
        clear_graph(4); add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3);
        build_model();
        launch();
        t = 0;
        while (!ifc.adj_rsp_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("reach_adj", 32'(ifc.adj_rsp_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset_mid_run");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prev_cycle = 1'b0;
        @(negedge clk);
        chk_zero("idle_after_mid_reset");
        build_model();
        launch(); wait_done();

        for (int r = 0; r < 40; r++) begin
            gen_random();
            build_model();
            launch();
            wait_done();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
